// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch stage.
package if_pkg;

  localparam int PC_W    = 64;
  localparam int INSTR_W = 32;

  // Canonical no-op (addi x0, x0, 0) available to consumers of fetch entries.
  localparam logic [INSTR_W-1:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_FETCH = 2'd1,
    ST_STALL = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous response buffer between instruction memory and decode.
// The head entry is presented directly from storage; when the buffer is
// empty the last popped entry is held on the output.
module fetch_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  fetch_entry_t  din_i,
  output fetch_entry_t  dout_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  last_q;
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          empty_s;
  logic          full_s;
  logic          pop_ok_s;

  assign empty_s  = (count_q == {CW{1'b0}});
  assign full_s   = (count_q == CW'(DEPTH));
  assign pop_ok_s = pop_i && !empty_s;
  assign empty_o  = empty_s;
  assign count_o  = count_q;
  assign dout_o   = empty_s ? last_q : mem_q[rd_ptr_q];

  // Pointer/count bookkeeping; a flush empties the buffer but a concurrent pop still records its entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
      last_q   <= '{pc: {PC_W{1'b0}}, instr: {INSTR_W{1'b0}}};
    end else begin
      if (pop_ok_s) begin
        last_q <= mem_q[rd_ptr_q];
      end
      if (flush_i) begin
        wr_ptr_q <= {PW{1'b0}};
        rd_ptr_q <= {PW{1'b0}};
        count_q  <= {CW{1'b0}};
      end else begin
        if (push_i) begin
          wr_ptr_q <= wr_ptr_q + PW'(1);
        end
        if (pop_ok_s) begin
          rd_ptr_q <= rd_ptr_q + PW'(1);
        end
        count_q <= count_q + CW'(push_i) - CW'(pop_ok_s);
      end
    end
  end

  // Storage write; contents need no reset because the count gates visibility.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  fetch_fifo_chk u_chk (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_i),
    .flush_i (flush_i),
    .full_i  (full_s)
  );

endmodule

// File: rtl/fetch_fifo_chk.sv
// Property checker for the fetch response buffer.
module fetch_fifo_chk (
  input logic clk,
  input logic rst,
  input logic push_i,
  input logic flush_i,
  input logic full_i
);

  // The credit scheme upstream must never let a response arrive into a full buffer.
  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst)
    !(push_i && full_i && !flush_i));

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch stage: PC register, one-deep in-flight tracking against a 1-cycle
// instruction memory, credit-based issue and a response buffer toward decode.
module instr_fetch_ctrl
  import if_pkg::*;
#(
  parameter int              FIFO_DEPTH = 2,
  parameter logic [PC_W-1:0] RESET_PC   = {PC_W{1'b0}}
) (
  input  logic               clk,
  input  logic               rst,
  output logic               mem_req,
  output logic [PC_W-1:0]    mem_pc,
  input  logic [INSTR_W-1:0] mem_instr,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [PC_W-1:0]    if_pc,
  output logic [INSTR_W-1:0] if_instr,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [PC_W-1:0]    fetch_pc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e    state_q;
  logic [PC_W-1:0] pc_q;
  logic            inflight_q;
  logic [PC_W-1:0] inflight_pc_q;

  logic [CW-1:0]   count_s;
  logic            empty_s;
  logic            deq_s;
  logic [CW:0]     occupancy_s;
  logic            credit_ok_s;
  logic            issue_s;
  logic            push_s;
  fetch_entry_t    push_entry_s;
  fetch_entry_t    head_s;

  assign deq_s        = !empty_s && if_ready;
  assign push_s       = inflight_q && !redirect_valid;
  assign push_entry_s = '{pc: inflight_pc_q, instr: mem_instr};

  // Occupancy after this cycle decides whether another fetch may be launched.
  always_comb begin
    occupancy_s = {1'b0, count_s} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, deq_s};
    credit_ok_s = (occupancy_s < (CW + 1)'(FIFO_DEPTH));
    if (redirect_valid) begin
      issue_s = 1'b0;
    end else if ((state_q == ST_FETCH) || (state_q == ST_STALL)) begin
      issue_s = credit_ok_s;
    end else begin
      issue_s = 1'b0;
    end
  end

  // Fetch FSM with PC and in-flight tracking; a redirect overrides every state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_RESET;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= {PC_W{1'b0}};
    end else if (redirect_valid) begin
      state_q    <= ST_FETCH;
      pc_q       <= redirect_pc;
      inflight_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RESET: begin
          state_q    <= ST_FETCH;
          inflight_q <= 1'b0;
        end
        ST_FETCH, ST_STALL: begin
          if (issue_s) begin
            state_q       <= ST_FETCH;
            pc_q          <= pc_q + {{(PC_W-1){1'b0}}, 1'b1};
            inflight_q    <= 1'b1;
            inflight_pc_q <= pc_q;
          end else begin
            state_q    <= ST_STALL;
            inflight_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= ST_RESET;
          inflight_q <= 1'b0;
        end
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_s),
    .pop_i   (deq_s),
    .flush_i (redirect_valid),
    .din_i   (push_entry_s),
    .dout_o  (head_s),
    .empty_o (empty_s),
    .count_o (count_s)
  );

  assign mem_req  = issue_s;
  assign mem_pc   = pc_q;
  assign fetch_pc = pc_q;
  assign if_valid = !empty_s;
  assign if_pc    = head_s.pc;
  assign if_instr = head_s.instr;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl with a scoreboard of expected deliveries.
module tb_instr_fetch_ctrl;
  import if_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               mem_req;
  logic [PC_W-1:0]    mem_pc;
  logic [INSTR_W-1:0] mem_instr;
  logic               if_valid;
  logic               if_ready;
  logic [PC_W-1:0]    if_pc;
  logic [INSTR_W-1:0] if_instr;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic [PC_W-1:0]    fetch_pc;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] exp_q[$];
  logic [63:0] all_ones = 64'hFFFF_FFFF_FFFF_FFFF;

  always #5 clk = ~clk;

  instr_fetch_ctrl #(
    .FIFO_DEPTH (2),
    .RESET_PC   (64'd10)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req        (mem_req),
    .mem_pc         (mem_pc),
    .mem_instr      (mem_instr),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_pc       (fetch_pc)
  );

  function automatic logic [31:0] mem_fn(input logic [63:0] pc);
    return pc[31:0] ^ 32'h5A5A_C3C3;
  endfunction

  // Memory model: one-cycle read latency.
  always @(posedge clk) begin
    if (mem_req) mem_instr <= mem_fn(mem_pc);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every decode handshake pops and compares one entry.
  always @(negedge clk) begin
    if (if_valid === 1'b1 && if_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_delivery: got pc %h expected none", if_pc);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("deliver_pc", if_pc, e);
        chk("deliver_instr", {32'd0, if_instr}, {32'd0, mem_fn(e)});
      end
    end
  end

  initial begin
    rst = 1'b0;
    if_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 64'd0;
    // 10,11 delivered; 12 dropped by redirect; 16..25 streamed; 26 flushed; wrap.
    exp_q.push_back(64'd10);
    exp_q.push_back(64'd11);
    for (int p = 16; p <= 25; p++) exp_q.push_back(64'(p));
    exp_q.push_back(all_ones);
    exp_q.push_back(64'd0);
    exp_q.push_back(64'd1);

    repeat (3) step();
    #1;
    chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
    chk("rst_if_valid", {63'd0, if_valid}, 64'd0);
    chk("rst_fetch_pc", fetch_pc, 64'd10);
    chk("rst_if_pc", if_pc, 64'd0);
    chk("rst_if_instr", {32'd0, if_instr}, 64'd0);

    rst = 1'b1;
    if_ready = 1'b1;
    #1 chk("c0_mem_req", {63'd0, mem_req}, 64'd0);
    step(); #1;
    chk("c1_mem_req", {63'd0, mem_req}, 64'd1);
    chk("c1_mem_pc", mem_pc, 64'd10);
    step(); #1;
    chk("c2_if_valid", {63'd0, if_valid}, 64'd0);
    chk("c2_mem_pc", mem_pc, 64'd11);
    step(); #1;
    chk("c3_if_valid", {63'd0, if_valid}, 64'd1);
    chk("c3_if_pc", if_pc, 64'd10);
    chk("c3_mem_pc", mem_pc, 64'd12);

    step();
    redirect_valid = 1'b1;
    redirect_pc = 64'd16;
    #1;
    chk("redir_mem_req", {63'd0, mem_req}, 64'd0);
    chk("redir_if_pc", if_pc, 64'd11);
    step();
    redirect_valid = 1'b0;
    #1;
    chk("post_redir_if_valid", {63'd0, if_valid}, 64'd0);
    chk("post_redir_mem_req", {63'd0, mem_req}, 64'd1);
    chk("post_redir_mem_pc", mem_pc, 64'd16);
    chk("post_redir_fetch_pc", fetch_pc, 64'd16);
    step(); #1;
    chk("c6_if_valid", {63'd0, if_valid}, 64'd0);
    chk("c6_mem_pc", mem_pc, 64'd17);
    step(); #1;
    chk("c7_if_valid", {63'd0, if_valid}, 64'd1);
    chk("c7_if_pc", if_pc, 64'd16);
    for (int i = 0; i < 4; i++) begin
      step(); #1;
      chk("stream_mem_req", {63'd0, mem_req}, 64'd1);
    end

    step();
    if_ready = 1'b0;
    #1;
    chk("bp_mem_req", {63'd0, mem_req}, 64'd0);
    chk("bp_if_pc", if_pc, 64'd21);
    for (int i = 0; i < 5; i++) begin
      step(); #1;
      chk("bp_hold_mem_req", {63'd0, mem_req}, 64'd0);
      chk("bp_hold_if_valid", {63'd0, if_valid}, 64'd1);
      chk("bp_hold_if_pc", if_pc, 64'd21);
    end
    chk("bp_count", {62'd0, dut.u_fifo.count_q}, 64'd2);
    step();
    if_ready = 1'b1;
    #1;
    chk("bp_release_mem_req", {63'd0, mem_req}, 64'd1);
    chk("bp_release_mem_pc", mem_pc, 64'd23);
    repeat (3) step();

    step();
    if_ready = 1'b0;
    #1 chk("full_if_pc", if_pc, 64'd25);
    step();
    step(); #1;
    chk("full_count", {62'd0, dut.u_fifo.count_q}, 64'd2);
    chk("full_mem_req", {63'd0, mem_req}, 64'd0);
    step();
    if_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = all_ones;
    #1;
    chk("rd_deq_mem_req", {63'd0, mem_req}, 64'd0);
    chk("rd_deq_if_pc", if_pc, 64'd25);
    step();
    redirect_valid = 1'b0;
    #1;
    chk("rd_deq_if_valid", {63'd0, if_valid}, 64'd0);
    chk("rd_deq_count", {62'd0, dut.u_fifo.count_q}, 64'd0);
    chk("rd_deq_mem_req2", {63'd0, mem_req}, 64'd1);
    chk("rd_deq_mem_pc", mem_pc, all_ones);
    step(); #1;
    chk("wrap_mem_pc", mem_pc, 64'd0);
    step(); #1;
    chk("wrap_if_pc_max", if_pc, all_ones);
    step(); #1;
    chk("wrap_if_pc_zero", if_pc, 64'd0);

    step();
    rst = 1'b0;
    #1 chk("pre_rst_if_pc", if_pc, 64'd1);
    step(); #1;
    chk("midrst_mem_req", {63'd0, mem_req}, 64'd0);
    chk("midrst_if_valid", {63'd0, if_valid}, 64'd0);
    chk("midrst_if_pc", if_pc, 64'd0);
    chk("midrst_if_instr", {32'd0, if_instr}, 64'd0);
    chk("midrst_fetch_pc", fetch_pc, 64'd10);

    rst = 1'b1;
    if_ready = 1'b0;
    repeat (2) step();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
